leaf_uplink_arbiter: RTL and testbench
======================================

# leaf_uplink_arbiter

Leaf-side uplink stage that merges up to NUM_SRC local endpoint streams into the single data/valid link feeding one leaf port of a spine router. A round-robin arbiter admits single-flit packets into an output FIFO. The FIFO drains under credit-based flow control, so the spine port's input FIFO can never overflow. One instance per leaf-to-spine link.

## Interface
- GROUP_ID, 4'b0100, group this leaf belongs to; exported in the status word only.
- LEAF_ID, 1, leaf index within the group; status word only.
- DWIDTH, 16, flit width; bits [DWIDTH-1:DWIDTH-6] carry the 6-bit destination address, which this block passes through untouched.
- NUM_SRC, 4, number of local source streams (2..8).
- FIFO_DEPTH, 8, output FIFO entries; power of two.
- CREDITS, 8, initial and maximum credit count; equals the spine port input FIFO depth.

Ports:
- clk  input  1  clock; all logic rising-edge.
- reset  input  1  asynchronous, active-high reset.
- src_data  input  NUM_SRC*DWIDTH  source flits; source i occupies [i*DWIDTH +: DWIDTH].
- src_valid  input  NUM_SRC  per-source flit valid.
- src_ready  output  NUM_SRC  per-source grant; combinational, one-hot or zero.
- up_data  output  DWIDTH  registered flit toward spine leaf port input.
- up_valid  output  1  registered; one flit per high cycle.
- credit_return  input  1  one-cycle pulse from the spine side; returns one credit.
- credit_count  output  $clog2(CREDITS+1)  current credits.
- fifo_count  output  $clog2(FIFO_DEPTH+1)  current FIFO occupancy.
- credit_err  output  1  sticky flag; set when a credit is returned while the count is already CREDITS.
- tx_state  output  2  drain FSM state: 0 IDLE, 1 SEND, 2 STALL.

## Operation
- **Admission:**
  - src_ready[i] is high only when fifo_count < FIFO_DEPTH, src_valid[i] is high, and i is the arbitration winner.
  - A transfer occurs when src_valid[i] and src_ready[i] are both high. The flit is written to the FIFO tail at that clock edge.
  - Sources must hold data and valid until ready.
- **Round-robin arbitration:**
  - A pointer rr_ptr names the highest-priority source. The search starts at rr_ptr and wraps modulo NUM_SRC.
  - After a transfer by source i, rr_ptr becomes (i+1) mod NUM_SRC. With no transfer, rr_ptr holds.
- **Full-FIFO admission:** the check uses occupancy before any same-cycle pop. When the FIFO is full, no source is admitted even if a pop occurs that cycle.
- **Drain FSM:**
  - IDLE: FIFO empty. Goes to SEND when fifo_count > 0 and credits > 0, or to STALL when fifo_count > 0 and credits == 0.
  - SEND: each cycle with fifo_count > 0 and credits > 0, pop the head into up_data, assert up_valid next cycle, and decrement credits. Goes to STALL when credits reach 0 with the FIFO non-empty, or to IDLE when the FIFO empties.
  - STALL: no pops. Goes to SEND when credits > 0.
  - The pop decision uses registered fifo_count and credit_count.
- **Credit arithmetic:**
  - A send with a simultaneous credit_return leaves the count unchanged.
  - A return with no send increments the count, saturating at CREDITS. A return at saturation is dropped and sets credit_err.
- **Reset (any time, asynchronous):**
  - Values: FIFO flushed, fifo_count = 0, credit_count = CREDITS, rr_ptr = 0, tx_state = IDLE, up_valid = 0, up_data = 0, credit_err = 0.
  - Flits in flight are lost; sources re-present after reset.

## Timing
- Flit admitted at edge E → up_valid high in the cycle after edge E+1. Minimum latency is 2 cycles when credits are available.
- Sustained throughput: one flit per cycle while credits > 0 and the FIFO is non-empty.
- A credit_return sampled at edge E is usable for a pop at edge E+1.
- src_ready is a combinational function of registered state and src_valid; it has no path from up_* or credit_return within the same cycle.
- up_valid is high for exactly one cycle per flit; up_data holds its last value when up_valid is low.

## Configuration
- ARB_FIXED_PRIO_EN defined: fixed priority, lowest asserted index wins, and rr_ptr is removed.
- ARB_FIXED_PRIO_EN undefined (default): round-robin as above.
- Drain, credit and reset behaviour are identical in both builds.

## Test plan
- **Reset and single flit:** after reset, credit_count = 8, fifo_count = 0, up_valid = 0. src 0 sends 16'hA401 → up_valid with up_data = 16'hA401 two cycles later; credit_count = 7.
- **Round-robin:** all 4 sources hold valid, with 8 credits returned continuously → grant order 0,1,2,3,0,1,…; no source starves. With ARB_FIXED_PRIO_EN, only source 0 is granted.
- **Credit exhaustion:** no credit_return, 12 flits offered → exactly 8 up_valid pulses, tx_state = STALL, fifo_count = 4. One credit_return pulse → exactly one further flit.
- **FIFO full:** credits held at 0, 8 flits pushed → fifo_count = 8 and src_ready = 0 for all sources. The first pop after a credit returns frees one slot the following cycle.
- **Simultaneous send and return:** credit_count = 3, a pop and a credit_return in the same cycle → credit_count stays 3. A return at credit_count = 8 → credit_err = 1 and stays set.
- **Mid-stream reset:** reset asserted while up_valid is toggling with fifo_count = 5 → all outputs return to reset values asynchronously; traffic resumes correctly after deassertion.

Source files
------------

// File: rtl/leaf_uplink_arbiter.sv
// leaf_uplink_arbiter
//
// Leaf-side uplink stage. Merges NUM_SRC local single-flit streams into one
// data/valid link toward a spine router leaf port. A round-robin arbiter admits
// flits into an output FIFO. The FIFO drains under credit-based flow control, so
// the spine input FIFO (CREDITS entries deep) can never overflow.
//
// Build option:
//   ARB_FIXED_PRIO_EN  when defined, the lowest asserted source index always
//                      wins and the round-robin pointer is removed. When it is
//                      undefined (the default), round-robin arbitration is used.
//
// Ports:
//   clk            rising-edge clock
//   reset          asynchronous, active-high reset
//   src_data       NUM_SRC packed flits; source i at [i*DWIDTH +: DWIDTH]
//   src_valid      per-source flit valid
//   src_ready      per-source grant; combinational, one-hot or zero
//   up_data        registered flit toward the spine; holds when up_valid is low
//   up_valid       registered; high for one cycle per flit
//   credit_return  one-cycle pulse that returns one credit
//   credit_count   current credits (0..CREDITS)
//   fifo_count     current output FIFO occupancy (0..FIFO_DEPTH)
//   credit_err     sticky; a credit came back while the count was already full
//   tx_state       drain FSM state: 0 idle, 1 send, 2 stall
//   status         {GROUP_ID, LEAF_ID[3:0]} identification word
module leaf_uplink_arbiter #(
    parameter logic [3:0]  GROUP_ID   = 4'b0100,
    parameter int unsigned LEAF_ID    = 1,
    parameter int unsigned DWIDTH     = 16,
    parameter int unsigned NUM_SRC    = 4,
    parameter int unsigned FIFO_DEPTH = 8,
    parameter int unsigned CREDITS    = 8
) (
    input  logic                              clk,
    input  logic                              reset,
    input  logic [NUM_SRC*DWIDTH-1:0]         src_data,
    input  logic [NUM_SRC-1:0]                src_valid,
    output logic [NUM_SRC-1:0]                src_ready,
    output logic [DWIDTH-1:0]                 up_data,
    output logic                              up_valid,
    input  logic                              credit_return,
    output logic [$clog2(CREDITS+1)-1:0]      credit_count,
    output logic [$clog2(FIFO_DEPTH+1)-1:0]   fifo_count,
    output logic                              credit_err,
    output logic [1:0]                        tx_state,
    output logic [7:0]                        status
);

    localparam int unsigned SRC_W  = $clog2(NUM_SRC);
    localparam int unsigned PTR_W  = $clog2(FIFO_DEPTH);
    localparam int unsigned CNT_W  = $clog2(CREDITS+1);
    localparam int unsigned FCNT_W = $clog2(FIFO_DEPTH+1);

    localparam logic [FCNT_W-1:0] FIFO_FULL  = FCNT_W'(FIFO_DEPTH);
    localparam logic [CNT_W-1:0]  CREDIT_MAX = CNT_W'(CREDITS);
    localparam logic [SRC_W-1:0]  LAST_SRC   = SRC_W'(NUM_SRC - 1);

    typedef enum logic [1:0] {
        StIdle  = 2'd0,
        StSend  = 2'd1,
        StStall = 2'd2
    } tx_state_e;

    // ------------------------------------------------------------------
    // State
    // ------------------------------------------------------------------
    logic [DWIDTH-1:0] mem [FIFO_DEPTH];
    logic [PTR_W-1:0]  wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0]  rd_ptr_q, rd_ptr_d;
    logic [FCNT_W-1:0] fifo_count_q, fifo_count_d;
    logic [CNT_W-1:0]  credit_q, credit_d;
    logic              credit_err_q, credit_err_d;
    tx_state_e         state_q, state_d;
    logic [DWIDTH-1:0] up_data_q;
    logic              up_valid_q;

    // ------------------------------------------------------------------
    // Arbitration
    // ------------------------------------------------------------------
    logic [SRC_W-1:0]  grant_idx;
    logic              grant_found;
    logic              not_full;
    logic              push;
    logic              pop;
    logic [DWIDTH-1:0] push_data;

`ifdef ARB_FIXED_PRIO_EN
    // Scan from the top down so the lowest asserted index is the last writer.
    always_comb begin
        grant_idx   = '0;
        grant_found = 1'b0;
        for (int i = NUM_SRC - 1; i >= 0; i--) begin
            if (src_valid[i]) begin
                grant_idx   = SRC_W'(i);
                grant_found = 1'b1;
            end
        end
    end
`else
    logic [SRC_W-1:0] rr_ptr_q, rr_ptr_d;

    // Scan offsets from farthest to nearest so the first valid source at or
    // after rr_ptr (wrapping) is the last writer and wins.
    always_comb begin
        int idx;
        grant_idx   = '0;
        grant_found = 1'b0;
        idx         = 0;
        for (int k = NUM_SRC - 1; k >= 0; k--) begin
            idx = int'(rr_ptr_q) + k;
            if (idx >= int'(NUM_SRC)) begin
                idx = idx - int'(NUM_SRC);
            end
            if (src_valid[SRC_W'(idx)]) begin
                grant_idx   = SRC_W'(idx);
                grant_found = 1'b1;
            end
        end
    end

    // The pointer moves only on an actual transfer.
    always_comb begin
        rr_ptr_d = rr_ptr_q;
        if (push) begin
            rr_ptr_d = (grant_idx == LAST_SRC) ? '0 : grant_idx + SRC_W'(1);
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            rr_ptr_q <= '0;
        end else begin
            rr_ptr_q <= rr_ptr_d;
        end
    end
`endif

    // Full check uses the registered occupancy, so a same-cycle pop never
    // opens a slot for admission in that cycle.
    assign not_full  = (fifo_count_q < FIFO_FULL);
    assign push      = grant_found && not_full;
    assign push_data = src_data[int'(grant_idx) * DWIDTH +: DWIDTH];

    always_comb begin
        src_ready = '0;
        if (push) begin
            src_ready[grant_idx] = 1'b1;
        end
    end

    // ------------------------------------------------------------------
    // FIFO and credit bookkeeping
    // ------------------------------------------------------------------
    // Pop purely from registered occupancy and credits; no same-cycle path
    // from credit_return or the source side.
    assign pop = (fifo_count_q != '0) && (credit_q != '0);

    always_comb begin
        wr_ptr_d     = wr_ptr_q;
        rd_ptr_d     = rd_ptr_q;
        fifo_count_d = fifo_count_q;
        if (push) begin
            wr_ptr_d = wr_ptr_q + PTR_W'(1);
        end
        if (pop) begin
            rd_ptr_d = rd_ptr_q + PTR_W'(1);
        end
        case ({push, pop})
            2'b10:   fifo_count_d = fifo_count_q + FCNT_W'(1);
            2'b01:   fifo_count_d = fifo_count_q - FCNT_W'(1);
            default: fifo_count_d = fifo_count_q;
        endcase
    end

    // A send and a return in the same cycle cancel. A return with no send
    // at the maximum is dropped and flagged.
    always_comb begin
        credit_d     = credit_q;
        credit_err_d = credit_err_q;
        case ({pop, credit_return})
            2'b10: credit_d = credit_q - CNT_W'(1);
            2'b01: begin
                if (credit_q == CREDIT_MAX) begin
                    credit_err_d = 1'b1;
                end else begin
                    credit_d = credit_q + CNT_W'(1);
                end
            end
            default: credit_d = credit_q;
        endcase
    end

    // ------------------------------------------------------------------
    // Drain FSM. Transitions look at next-cycle occupancy and credits so the
    // state always agrees with the registered counters it reports beside.
    // ------------------------------------------------------------------
    always_comb begin
        state_d = state_q;
        case (state_q)
            StIdle: begin
                if (fifo_count_d != '0) begin
                    state_d = (credit_d != '0) ? StSend : StStall;
                end
            end
            StSend: begin
                if (fifo_count_d == '0) begin
                    state_d = StIdle;
                end else if (credit_d == '0) begin
                    state_d = StStall;
                end
            end
            StStall: begin
                if (fifo_count_d == '0) begin
                    state_d = StIdle;
                end else if (credit_d != '0) begin
                    state_d = StSend;
                end
            end
            default: state_d = StIdle;
        endcase
    end

    // ------------------------------------------------------------------
    // Registers
    // ------------------------------------------------------------------
    // Storage needs no reset; the pointers and count define its contents.
    always_ff @(posedge clk) begin
        if (push) begin
            mem[wr_ptr_q] <= push_data;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            wr_ptr_q     <= '0;
            rd_ptr_q     <= '0;
            fifo_count_q <= '0;
            credit_q     <= CREDIT_MAX;
            credit_err_q <= 1'b0;
            state_q      <= StIdle;
            up_data_q    <= '0;
            up_valid_q   <= 1'b0;
        end else begin
            wr_ptr_q     <= wr_ptr_d;
            rd_ptr_q     <= rd_ptr_d;
            fifo_count_q <= fifo_count_d;
            credit_q     <= credit_d;
            credit_err_q <= credit_err_d;
            state_q      <= state_d;
            up_valid_q   <= pop;
            if (pop) begin
                up_data_q <= mem[rd_ptr_q];
            end
        end
    end

    // ------------------------------------------------------------------
    // Outputs
    // ------------------------------------------------------------------
    assign up_data      = up_data_q;
    assign up_valid     = up_valid_q;
    assign credit_count = credit_q;
    assign fifo_count   = fifo_count_q;
    assign credit_err   = credit_err_q;
    assign tx_state     = state_q;
    assign status       = {GROUP_ID, 4'(LEAF_ID)};

endmodule

// File: tb/tb_leaf_uplink_arbiter.sv
module tb_leaf_uplink_arbiter;

    localparam int unsigned DWIDTH     = 16;
    localparam int unsigned NUM_SRC    = 4;
    localparam int unsigned FIFO_DEPTH = 8;
    localparam int unsigned CREDITS    = 8;

    logic                      clk = 1'b0;
    logic                      reset = 1'b1;
    logic [NUM_SRC*DWIDTH-1:0] src_data = '0;
    logic [NUM_SRC-1:0]        src_valid = '0;
    logic [NUM_SRC-1:0]        src_ready;
    logic [DWIDTH-1:0]         up_data;
    logic                      up_valid;
    logic                      credit_return = 1'b0;
    logic [3:0]                credit_count;
    logic [3:0]                fifo_count;
    logic                      credit_err;
    logic [1:0]                tx_state;
    logic [7:0]                status;

    int checks = 0;
    int errors = 0;
    int n_up   = 0;
    int seq    = 0;
    int pend [NUM_SRC];
    logic [DWIDTH-1:0] exp_q [$];
    int grants [$];

    leaf_uplink_arbiter #(
        .GROUP_ID  (4'b0100),
        .LEAF_ID   (1),
        .DWIDTH    (DWIDTH),
        .NUM_SRC   (NUM_SRC),
        .FIFO_DEPTH(FIFO_DEPTH),
        .CREDITS   (CREDITS)
    ) dut (
        .clk          (clk),
        .reset        (reset),
        .src_data     (src_data),
        .src_valid    (src_valid),
        .src_ready    (src_ready),
        .up_data      (up_data),
        .up_valid     (up_valid),
        .credit_return(credit_return),
        .credit_count (credit_count),
        .fifo_count   (fifo_count),
        .credit_err   (credit_err),
        .tx_state     (tx_state),
        .status       (status)
    );

    always #5 clk = ~clk;

    initial begin
        #2_000_000;
        $display("FAIL watchdog: observed timeout required finish");
        $fatal(1);
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic refresh_valid();
        for (int i = 0; i < NUM_SRC; i++) begin
            src_valid[i] = (pend[i] > 0);
        end
    endtask

    task automatic new_flit(input int i);
        seq++;
        src_data[i*DWIDTH +: DWIDTH] = {6'(i + 16), 10'(seq)};
    endtask

    task automatic offer(input int i, input int n);
        pend[i] = n;
        new_flit(i);
        refresh_valid();
    endtask

    function automatic int pend_total();
        int t = 0;
        for (int i = 0; i < NUM_SRC; i++) begin
            t += pend[i];
        end
        return t;
    endfunction

    // One clock: sample at the falling edge, then advance sources after the
    // rising edge according to the handshakes seen.
    task automatic step();
        logic [NUM_SRC-1:0] hs;
        hs = '0;
        @(negedge clk);
        if (!reset) begin
            check("ready_onehot0", 32'($onehot0(src_ready)), 32'd1);
            check("ready_needs_valid", 32'(src_ready & ~src_valid), 32'd0);
            if (up_valid) begin
                n_up++;
                if (exp_q.size() == 0) begin
                    check("unexpected_flit", 32'(exp_q.size()), 32'd1);
                end else begin
                    check("up_data", 32'(up_data), 32'(exp_q.pop_front()));
                end
            end
            hs = src_valid & src_ready;
            for (int i = 0; i < NUM_SRC; i++) begin
                if (hs[i]) begin
                    exp_q.push_back(src_data[i*DWIDTH +: DWIDTH]);
                    grants.push_back(i);
                end
            end
        end
        @(posedge clk);
        #1;
        for (int i = 0; i < NUM_SRC; i++) begin
            if (hs[i]) begin
                pend[i]--;
                if (pend[i] > 0) begin
                    new_flit(i);
                end
            end
        end
        refresh_valid();
    endtask

    task automatic clear_traffic();
        for (int i = 0; i < NUM_SRC; i++) begin
            pend[i] = 0;
        end
        refresh_valid();
        credit_return = 1'b0;
        exp_q.delete();
        grants.delete();
        n_up = 0;
    endtask

    task automatic do_reset();
        reset = 1'b1;
        clear_traffic();
        repeat (2) step();
        reset = 1'b0;
    endtask

    // Return credits (never at the maximum) until everything has drained.
    task automatic drain();
        int n = 0;
        while (n < 300 && !(fifo_count == 0 && credit_count == 4'(CREDITS) &&
               pend_total() == 0 && !up_valid && exp_q.size() == 0)) begin
            credit_return = (credit_count < 4'(CREDITS));
            step();
            n++;
        end
        credit_return = 1'b0;
        check("drain_in_budget", 32'(n < 300), 32'd1);
    endtask

    initial begin
        int exp_grant;
        for (int i = 0; i < NUM_SRC; i++) begin
            pend[i] = 0;
        end

        // Reset values
        do_reset();
        check("rst_credit", 32'(credit_count), 32'd8);
        check("rst_fifo", 32'(fifo_count), 32'd0);
        check("rst_up_valid", 32'(up_valid), 32'd0);
        check("rst_up_data", 32'(up_data), 32'd0);
        check("rst_tx_state", 32'(tx_state), 32'd0);
        check("rst_credit_err", 32'(credit_err), 32'd0);
        check("status", 32'(status), 32'h41);

        // Single flit, two-cycle latency
        pend[0] = 1;
        src_data[15:0] = 16'hA401;
        refresh_valid();
        step();
        check("single_fifo", 32'(fifo_count), 32'd1);
        check("single_tx_send", 32'(tx_state), 32'd1);
        step();
        check("single_up_valid", 32'(up_valid), 32'd1);
        check("single_up_data", 32'(up_data), 32'hA401);
        check("single_credit", 32'(credit_count), 32'd7);
        check("single_tx_idle", 32'(tx_state), 32'd0);
        step();
        check("single_n_up", 32'(n_up), 32'd1);
        check("single_pulse", 32'(up_valid), 32'd0);
        check("single_hold", 32'(up_data), 32'hA401);
        credit_return = 1'b1;
        step();
        credit_return = 1'b0;
        check("credit_restore", 32'(credit_count), 32'd8);

        // Credit exhaustion: 12 flits, no returns
        n_up = 0;
        offer(0, 12);
        repeat (3) step();
        check("exh_tx_send", 32'(tx_state), 32'd1);
        repeat (27) step();
        check("exh_n_up", 32'(n_up), 32'd8);
        check("exh_fifo", 32'(fifo_count), 32'd4);
        check("exh_tx_stall", 32'(tx_state), 32'd2);
        check("exh_credit", 32'(credit_count), 32'd0);
        check("exh_sb_depth", 32'(exp_q.size()), 32'd4);
        credit_return = 1'b1;
        step();
        credit_return = 1'b0;
        repeat (5) step();
        check("exh_one_more", 32'(n_up), 32'd9);
        check("exh_fifo_after", 32'(fifo_count), 32'd3);
        check("exh_stall_again", 32'(tx_state), 32'd2);

        // FIFO full with credits at zero
        offer(1, 5);
        offer(2, 3);
        repeat (12) step();
        check("full_fifo", 32'(fifo_count), 32'd8);
        check("full_ready", 32'(src_ready), 32'd0);
        check("full_pending", 32'(pend_total()), 32'd3);
        credit_return = 1'b1;
        step();
        credit_return = 1'b0;
        check("full_credit_back", 32'(credit_count), 32'd1);
        check("full_ready_still0", 32'(src_ready), 32'd0);
        step();
        check("full_popped", 32'(fifo_count), 32'd7);
        check("full_slot_free", 32'($countones(src_ready)), 32'd1);
        step();
        check("full_refilled", 32'(fifo_count), 32'd8);
        drain();
        check("full_drained_err", 32'(credit_err), 32'd0);

        // Simultaneous send and return
        n_up = 0;
        offer(3, 5);
        repeat (12) step();
        check("sim_credit3", 32'(credit_count), 32'd3);
        check("sim_n_up5", 32'(n_up), 32'd5);
        offer(3, 1);
        step();
        credit_return = 1'b1;
        step();
        credit_return = 1'b0;
        check("sim_credit_unchanged", 32'(credit_count), 32'd3);
        check("sim_fifo", 32'(fifo_count), 32'd0);
        step();
        check("sim_n_up6", 32'(n_up), 32'd6);
        credit_return = 1'b1;
        step();
        credit_return = 1'b0;
        check("ret_increment", 32'(credit_count), 32'd4);
        drain();
        check("ret_no_err", 32'(credit_err), 32'd0);
        credit_return = 1'b1;
        step();
        credit_return = 1'b0;
        check("sat_err", 32'(credit_err), 32'd1);
        check("sat_credit", 32'(credit_count), 32'd8);
        repeat (3) step();
        check("sat_err_sticky", 32'(credit_err), 32'd1);

        // Arbitration order with all sources requesting
        do_reset();
        check("rr_err_cleared", 32'(credit_err), 32'd0);
        for (int i = 0; i < NUM_SRC; i++) begin
            offer(i, 6);
        end
        repeat (60) begin
            credit_return = (credit_count < 4'(CREDITS));
            step();
        end
        credit_return = 1'b0;
        check("rr_grant_count", 32'(grants.size()), 32'd24);
        for (int k = 0; k < 24 && k < grants.size(); k++) begin
`ifdef ARB_FIXED_PRIO_EN
            exp_grant = k / 6;
`else
            exp_grant = k % 4;
`endif
            check("grant_order", 32'(grants[k]), 32'(exp_grant));
        end
        drain();
        check("rr_sb_empty", 32'(exp_q.size()), 32'd0);

        // Mid-stream asynchronous reset
        n_up = 0;
        offer(2, 14);
        repeat (30) step();
        check("mid_fifo6", 32'(fifo_count), 32'd6);
        check("mid_n_up8", 32'(n_up), 32'd8);
        credit_return = 1'b1;
        step();
        credit_return = 1'b0;
        step();
        check("mid_up_valid", 32'(up_valid), 32'd1);
        check("mid_fifo5", 32'(fifo_count), 32'd5);
        #2;
        reset = 1'b1;
        #1;
        check("arst_up_valid", 32'(up_valid), 32'd0);
        check("arst_up_data", 32'(up_data), 32'd0);
        check("arst_fifo", 32'(fifo_count), 32'd0);
        check("arst_credit", 32'(credit_count), 32'd8);
        check("arst_tx_state", 32'(tx_state), 32'd0);
        clear_traffic();
        repeat (2) step();
        reset = 1'b0;
        offer(1, 3);
        drain();
        check("resume_n_up", 32'(n_up), 32'd3);
        check("resume_fifo", 32'(fifo_count), 32'd0);
        check("resume_tx_idle", 32'(tx_state), 32'd0);
        check("resume_err", 32'(credit_err), 32'd0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
